imem_load_ctrl: RTL and testbench

//  Sequences program loading into the instruction memory: optional NOP-fill, then word-by-word

---
 rtl/imem_load_ctrl_if.sv | 13 +
 rtl/imem_load_ctrl.sv | 145 ++++++++++++++
 tb/tb_imem_load_ctrl.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/imem_load_ctrl_if.sv
// Loader stream handshake between the boot/debug source and the load controller.
interface imem_load_ctrl_if #(
  parameter int unsigned INSTR_WIDTH = 32
) ();

  logic                   valid;
  logic [INSTR_WIDTH-1:0] data;
  logic                   ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/imem_load_ctrl.sv
// Instruction memory load sequencer: optional NOP-fill, then stream-driven word writes,
// with core fetch held off while the memory is being modified.
module imem_load_ctrl #(
  parameter int unsigned ROM_SIZE = 256,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned INSTR_WIDTH = 32,
  parameter logic [INSTR_WIDTH-1:0] NOP_WORD = INSTR_WIDTH'(32'h00000013),
  parameter bit CLEAR_ON_START = 1'b1,
  localparam int unsigned AW = $clog2(ROM_SIZE)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [DATA_WIDTH-1:0]  load_base,
  input  logic [AW:0]            load_count,
  imem_load_ctrl_if.slave        s,
  output logic                   mem_we,
  output logic [AW-1:0]          mem_waddr,
  output logic [INSTR_WIDTH-1:0] mem_wdata,
  output logic                   core_hold,
  output logic                   busy,
  output logic                   done,
  output logic                   error
);

  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, FLUSH, DONE} state_t;

  state_t                 state, state_n;
  logic [AW-1:0]          base_r, base_n;
  logic [AW:0]            count_r, count_n;
  logic [AW:0]            idx, idx_n;
  logic                   we_n, busy_n, done_n, error_n;
  logic [AW-1:0]          waddr_n;
  logic [INSTR_WIDTH-1:0] wdata_n;

  logic [AW-1:0]          base_w;
  logic [AW+1:0]          end_w;
  logic                   reject;

  // Start request validation: alignment, base range, and no write past the end of memory.
  always_comb begin
    base_w = load_base[AW+1:2];
    end_w  = (AW+2)'(base_w) + (AW+2)'(load_count);
    reject = (load_base[1:0] != 2'b00)
          || (((load_base >> 2) >= DATA_WIDTH'(ROM_SIZE)) && (load_count != '0))
          || (end_w > (AW+2)'(ROM_SIZE));
  end

  assign s.ready = (state == LOAD);

  // Next state and next values of the registered outputs.
  always_comb begin
    state_n = state;
    base_n  = base_r;
    count_n = count_r;
    idx_n   = idx;
    error_n = error;
    we_n    = 1'b0;
    waddr_n = mem_waddr;
    wdata_n = mem_wdata;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          if (reject) begin
            error_n = 1'b1;
          end else begin
            error_n = 1'b0;
            base_n  = base_w;
            count_n = load_count;
            idx_n   = '0;
            if (CLEAR_ON_START) begin
              state_n = CLEAR;
              we_n    = 1'b1;
              waddr_n = '0;
              wdata_n = NOP_WORD;
            end else if (load_count == '0) begin
              state_n = FLUSH;
            end else begin
              state_n = LOAD;
            end
          end
        end
      end
      CLEAR: begin
        // mem_waddr holds the address being filled this cycle
        if (mem_waddr == AW'(ROM_SIZE - 1)) begin
          state_n = (count_r == '0) ? FLUSH : LOAD;
        end else begin
          we_n    = 1'b1;
          waddr_n = mem_waddr + AW'(1);
          wdata_n = NOP_WORD;
        end
      end
      LOAD: begin
        if (s.valid) begin
          we_n    = 1'b1;
          waddr_n = base_r + idx[AW-1:0];
          wdata_n = s.data;
          idx_n   = idx + (AW+1)'(1);
          if (idx_n == count_r) begin
            state_n = FLUSH;
          end
        end
      end
      FLUSH: begin
        state_n = DONE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    busy_n = (state_n == CLEAR) || (state_n == LOAD) || (state_n == FLUSH);
    done_n = (state_n == DONE) && (state != DONE);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      base_r    <= '0;
      count_r   <= '0;
      idx       <= '0;
      mem_we    <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
      core_hold <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      state     <= state_n;
      base_r    <= base_n;
      count_r   <= count_n;
      idx       <= idx_n;
      mem_we    <= we_n;
      mem_waddr <= waddr_n;
      mem_wdata <= wdata_n;
      core_hold <= busy_n;
      busy      <= busy_n;
      done      <= done_n;
      error     <= error_n;
    end
  end

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Bench for imem_load_ctrl: one instance without clear (main tests), one with NOP-fill.
module tb_imem_load_ctrl;

  localparam int unsigned ROM = 256;
  localparam logic [31:0] NOP = 32'h00000013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start0, start1;
  logic [31:0] base0, base1;
  logic [8:0]  count0, count1;
  logic        mem_we0, mem_we1;
  logic [7:0]  waddr0, waddr1;
  logic [31:0] wdata0, wdata1;
  logic        hold0, hold1, busy0, busy1, done0, done1, error0, error1;

  imem_load_ctrl_if #(.INSTR_WIDTH(32)) if0 ();
  imem_load_ctrl_if #(.INSTR_WIDTH(32)) if1 ();

  imem_load_ctrl #(.ROM_SIZE(ROM), .CLEAR_ON_START(1'b0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .load_base(base0), .load_count(count0),
    .s(if0), .mem_we(mem_we0), .mem_waddr(waddr0), .mem_wdata(wdata0),
    .core_hold(hold0), .busy(busy0), .done(done0), .error(error0));

  imem_load_ctrl #(.ROM_SIZE(ROM), .CLEAR_ON_START(1'b1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .load_base(base1), .load_count(count1),
    .s(if1), .mem_we(mem_we1), .mem_waddr(waddr1), .mem_wdata(wdata1),
    .core_hold(hold1), .busy(busy1), .done(done1), .error(error1));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] base;
    int          cnt;
    int          vmode;  // 0: valid always, 1: toggling 1,0,1.., 2: random
    bit          err;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {s_ready, busy, core_hold, done, error}
  function automatic logic [4:0] ctl0();
    return {if0.ready, busy0, hold0, done0, error0};
  endfunction

  function automatic logic [4:0] ctl1();
    return {if1.ready, busy1, hold1, done1, error1};
  endfunction

  task automatic chk_wr0(input string nm, input bit we, input logic [7:0] a, input logic [31:0] d);
    if (we) chk(nm, 64'({mem_we0, waddr0, wdata0}), 64'({1'b1, a, d}));
    else    chk(nm, 64'(mem_we0), 64'(1'b0));
  endtask

  task automatic chk_wr1(input string nm, input bit we, input logic [7:0] a, input logic [31:0] d);
    if (we) chk(nm, 64'({mem_we1, waddr1, wdata1}), 64'({1'b1, a, d}));
    else    chk(nm, 64'(mem_we1), 64'(1'b0));
  endtask

  // Reference rule for rejecting a start request, from plain integer arithmetic.
  function automatic bit rej(input logic [31:0] b, input int cnt);
    int unsigned word = 32'(b >> 2);
    return (b[1:0] != 2'b00) || ((word >= ROM) && (cnt > 0)) || ((word % ROM) + 32'(cnt) > ROM);
  endfunction

  // One start request on the no-clear instance, streamed and checked cycle by cycle.
  task automatic run_txn0(input logic [31:0] b, input int cnt, input int vmode, input bit exp_err);
    int rem, idx, cyc;
    bit hs, v;
    logic [7:0]  a, bw;
    logic [31:0] d;
    bw = b[9:2];
    if0.valid = 1'b0;
    start0 = 1'b1; base0 = b; count0 = 9'(cnt);
    step();
    start0 = 1'b0;
    if (exp_err) begin
      chk("reject_ctl", 64'(ctl0()), 64'(5'b00001));
      chk_wr0("reject_we", 1'b0, 8'h0, 32'h0);
      step();
      chk("reject_hold", 64'(ctl0()), 64'(5'b00001));
      return;
    end
    rem = cnt; idx = 0; cyc = 0; hs = 1'b0; a = '0; d = '0;
    while (rem > 0) begin
      chk("load_ctl", 64'(ctl0()), 64'(5'b11100));
      chk_wr0("load_wr", hs, a, d);
      v = (vmode == 0) ? 1'b1 : (vmode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      if0.valid = v;
      if0.data  = $urandom;
      hs = v;
      if (v) begin
        a = bw + 8'(idx);
        d = if0.data;
        idx++;
        rem--;
      end
      cyc++;
      step();
    end
    if0.valid = 1'b0;
    chk("flush_ctl", 64'(ctl0()), 64'(5'b01100));
    chk_wr0("flush_wr", hs, a, d);
    step();
    chk("done_ctl", 64'(ctl0()), 64'(5'b00010));
    chk_wr0("done_we", 1'b0, 8'h0, 32'h0);
    step();
    chk("after_done_ctl", 64'(ctl0()), 64'(5'b00000));
  endtask

  initial begin
    tbl[0]  = '{32'h0000_0040,   3, 1, 1'b0};
    tbl[1]  = '{32'h0000_03FC,   2, 0, 1'b1};
    tbl[2]  = '{32'h0000_03FC,   1, 0, 1'b0};
    tbl[3]  = '{32'h0000_0002,   1, 0, 1'b1};
    tbl[4]  = '{32'h0000_0000,   0, 0, 1'b0};
    tbl[5]  = '{32'h0000_0400,   1, 0, 1'b1};
    tbl[6]  = '{32'h0000_0400,   0, 0, 1'b0};
    tbl[7]  = '{32'h0000_03F8,   2, 2, 1'b0};
    tbl[8]  = '{32'h0000_03F8,   3, 0, 1'b1};
    tbl[9]  = '{32'h0000_0004, 256, 0, 1'b1};
    tbl[10] = '{32'h0000_0000, 256, 2, 1'b0};
    tbl[11] = '{32'h0000_0000, 257, 0, 1'b1};

    rst = 1'b1;
    start0 = 1'b0; base0 = '0; count0 = '0; if0.valid = 1'b0; if0.data = '0;
    start1 = 1'b0; base1 = '0; count1 = '0; if1.valid = 1'b0; if1.data = '0;
    repeat (3) step();
    rst = 1'b0;
    chk("reset_ctl0", 64'(ctl0()), 64'(5'b00000));
    chk("reset_mem0", 64'({mem_we0, waddr0, wdata0}), 64'(0));
    chk("reset_ctl1", 64'(ctl1()), 64'(5'b00000));
    chk("reset_mem1", 64'({mem_we1, waddr1, wdata1}), 64'(0));

    // NOP-fill of the whole memory, then four back-to-back words at 0..3.
    start1 = 1'b1; base1 = '0; count1 = 9'd4;
    step();
    start1 = 1'b0;
    for (int i = 0; i < 256; i++) begin
      chk("clear_cycle", 64'({ctl1(), mem_we1, waddr1, wdata1}),
          64'({5'b01100, 1'b1, 8'(i), NOP}));
      step();
    end
    for (int k = 0; k < 4; k++) begin
      chk("clr_load_ctl", 64'(ctl1()), 64'(5'b11100));
      chk_wr1("clr_load_wr", k > 0, 8'(k - 1), 32'hA0A0_0000 + 32'(k - 1));
      if1.valid = 1'b1;
      if1.data  = 32'hA0A0_0000 + 32'(k);
      step();
    end
    if1.valid = 1'b0;
    chk("clr_flush_ctl", 64'(ctl1()), 64'(5'b01100));
    chk_wr1("clr_flush_wr", 1'b1, 8'd3, 32'hA0A0_0003);
    step();
    chk("clr_done_ctl", 64'(ctl1()), 64'(5'b00010));
    chk_wr1("clr_done_we", 1'b0, 8'h0, 32'h0);
    step();
    chk("clr_after_ctl", 64'(ctl1()), 64'(5'b00000));

    // Clear with zero words goes straight from the last fill write to FLUSH.
    start1 = 1'b1; base1 = 32'h10; count1 = 9'd0;
    step();
    start1 = 1'b0;
    repeat (256) step();
    chk("clr0_flush_ctl", 64'(ctl1()), 64'(5'b01100));
    chk_wr1("clr0_flush_we", 1'b0, 8'h0, 32'h0);
    step();
    chk("clr0_done_ctl", 64'(ctl1()), 64'(5'b00010));

    // Directed validation / boundary vectors.
    for (int i = 0; i < 12; i++) begin
      run_txn0(tbl[i].base, tbl[i].cnt, tbl[i].vmode, tbl[i].err);
    end

    // Randomized requests against the reference rule.
    for (int n = 0; n < 30; n++) begin
      logic [31:0] b;
      int c, r;
      r = int'($urandom_range(0, 9));
      if (r < 7)       b = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      else if (r == 7) b = {22'h0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
      else             b = 32'($urandom_range(0, 2047));
      c = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 511)) : int'($urandom_range(0, 40));
      run_txn0(b, c, 2, rej(b, c));
    end

    // Start while busy is ignored; reset mid-load returns to idle with no further writes.
    start0 = 1'b1; base0 = '0; count0 = 9'd4;
    step();
    start0 = 1'b0;
    chk("rst_seq_accept", 64'(ctl0()), 64'(5'b11100));
    if0.valid = 1'b1; if0.data = 32'h1111_1111;
    start0 = 1'b1; base0 = 32'h2;
    step();
    start0 = 1'b0;
    chk("busy_start_ignored", 64'(ctl0()), 64'(5'b11100));
    chk_wr0("rst_seq_wr0", 1'b1, 8'd0, 32'h1111_1111);
    if0.data = 32'h2222_2222;
    step();
    chk_wr0("rst_seq_wr1", 1'b1, 8'd1, 32'h2222_2222);
    if0.valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_ctl", 64'(ctl0()), 64'(5'b00000));
    chk_wr0("rst_mid_we", 1'b0, 8'h0, 32'h0);
    step();
    chk("rst_after_ctl", 64'(ctl0()), 64'(5'b00000));
    chk_wr0("rst_after_we", 1'b0, 8'h0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
